if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage_if.sv | 43 ++++
 rtl/if_fetch_stage.sv | 94 +++++++++
 tb/tb_if_fetch_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Interface bundle between the fetch stage, the hazard unit, EX redirect logic,
// the instruction memory and the IF/ID consumer.
// The fetch stage connects through the master modport.
// Optional macro IF_FETCH_PERF_CNT_EN adds three 32-bit performance counters.
interface if_fetch_stage_if #(
    parameter int n = 32
);
    logic         freeze;
    logic         br_taken;
    logic [n-1:0] br_target;
    logic [n-1:0] instruction;
    logic [n-1:0] pc;
    logic [n-1:0] ifid_pc;
    logic [n-1:0] ifid_instruction;
    logic         ifid_valid;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0]  fetch_count;
    logic [31:0]  stall_count;
    logic [31:0]  flush_count;

    modport master (
        input  freeze, br_taken, br_target, instruction,
        output pc, ifid_pc, ifid_instruction, ifid_valid,
        output fetch_count, stall_count, flush_count
    );

    modport slave (
        output freeze, br_taken, br_target, instruction,
        input  pc, ifid_pc, ifid_instruction, ifid_valid,
        input  fetch_count, stall_count, flush_count
    );
`else
    modport master (
        input  freeze, br_taken, br_target, instruction,
        output pc, ifid_pc, ifid_instruction, ifid_valid
    );

    modport slave (
        output freeze, br_taken, br_target, instruction,
        input  pc, ifid_pc, ifid_instruction, ifid_valid
    );
`endif
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and captures the returned word into the IF/ID register.
// Per-edge priority: rst > br_taken (redirect + flush) > freeze (hold) > advance.
// Optional macro IF_FETCH_PERF_CNT_EN adds fetch/stall/flush event counters.
module if_fetch_stage #(
    parameter int n       = 32,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_stage_if.master bus
);
    logic [n-1:0] pc_reg, pc_next;
    logic [n-1:0] ifid_pc_reg, ifid_pc_next;
    logic [n-1:0] ifid_instr_reg, ifid_instr_next;
    logic         ifid_valid_reg, ifid_valid_next;
    logic [n-1:0] pc_inc;
    logic         do_flush, do_stall, do_advance;

    // Exactly one of these is high on every non-reset cycle.
    assign do_flush   = bus.br_taken;
    assign do_stall   = bus.freeze & ~bus.br_taken;
    assign do_advance = ~bus.freeze & ~bus.br_taken;

    // Sequential address wraps modulo 2^n with no flag.
    assign pc_inc = pc_reg + n'(PC_STEP);

    // Next-state selection for PC and the IF/ID register.
    always_comb begin
        pc_next         = pc_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_instr_next = ifid_instr_reg;
        ifid_valid_next = ifid_valid_reg;
        if (do_flush) begin
            // Redirect is word-aligned; the wrong-path word at pc is dropped
            // and IF/ID becomes an all-zero (NOP) bubble.
            pc_next         = {bus.br_target[n-1:2], 2'b00};
            ifid_pc_next    = '0;
            ifid_instr_next = '0;
            ifid_valid_next = 1'b0;
        end else if (do_advance) begin
            pc_next         = pc_inc;
            ifid_pc_next    = pc_inc;
            ifid_instr_next = bus.instruction;
            ifid_valid_next = 1'b1;
        end
    end

    // PC and IF/ID registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg         <= '0;
            ifid_pc_reg    <= '0;
            ifid_instr_reg <= '0;
            ifid_valid_reg <= 1'b0;
        end else begin
            pc_reg         <= pc_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_instr_reg <= ifid_instr_next;
            ifid_valid_reg <= ifid_valid_next;
        end
    end

    assign bus.pc               = pc_reg;
    assign bus.ifid_pc          = ifid_pc_reg;
    assign bus.ifid_instruction = ifid_instr_reg;
    assign bus.ifid_valid       = ifid_valid_reg;

`ifdef IF_FETCH_PERF_CNT_EN
    logic [2:0] perf_event;

    // Index 0 = fetch, 1 = stall, 2 = flush.
    assign perf_event = {do_flush, do_stall, do_advance};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : perf_gen
            logic [31:0] cnt_reg;

            // Free-running event counter, wraps modulo 2^32.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (perf_event[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign bus.fetch_count = perf_gen[0].cnt_reg;
    assign bus.stall_count = perf_gen[1].cnt_reg;
    assign bus.flush_count = perf_gen[2].cnt_reg;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage. Instruction memory returns word = address.
// Counter checks are compiled in when IF_FETCH_PERF_CNT_EN is defined.
module tb_if_fetch_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    if_fetch_stage_if #(.n(32)) bus ();

    if_fetch_stage #(.n(32), .PC_STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational instruction memory: word at address A is A.
    assign bus.instruction = bus.pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] e_pc,
                                input logic [31:0] e_ipc, input logic [31:0] e_instr,
                                input logic e_valid);
        check({tag, ".pc"}, bus.pc, e_pc);
        check({tag, ".ifid_pc"}, bus.ifid_pc, e_ipc);
        check({tag, ".ifid_instr"}, bus.ifid_instruction, e_instr);
        check({tag, ".ifid_valid"}, {31'd0, bus.ifid_valid}, {31'd0, e_valid});
        $display("%s: pc=0x%08h ifid_pc=0x%08h ifid_instr=0x%08h valid=%0d",
                 tag, bus.pc, bus.ifid_pc, bus.ifid_instruction, bus.ifid_valid);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.freeze    = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = 32'd0;

        step();
        step();
        expect_state("reset", 32'd0, 32'd0, 32'd0, 1'b0);

        // Free run: after i edges pc=4i, IF/ID holds word 4(i-1).
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            expect_state($sformatf("run%0d", i), 32'(4 * i), 32'(4 * i), 32'(4 * (i - 1)), 1'b1);
        end

        // Freeze three cycles at pc=12.
        bus.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state($sformatf("freeze%0d", i), 32'd12, 32'd12, 32'd8, 1'b1);
        end
        bus.freeze = 1'b0;
        step();
        expect_state("release0", 32'd16, 32'd16, 32'd12, 1'b1);
        step();
        expect_state("release1", 32'd20, 32'd20, 32'd16, 1'b1);

        // Advance up to pc=40.
        for (int i = 6; i <= 10; i++) begin
            step();
            expect_state($sformatf("run%0d", i), 32'(4 * i), 32'(4 * i), 32'(4 * (i - 1)), 1'b1);
        end

        // Redirect with unaligned target.
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_009E;
        step();
        expect_state("branch", 32'h9C, 32'd0, 32'd0, 1'b0);
        bus.br_taken = 1'b0;
        step();
        expect_state("branch_next", 32'hA0, 32'hA0, 32'h9C, 1'b1);

        // Back-to-back redirects: last target wins, bubble stays.
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_0200;
        step();
        expect_state("br2_a", 32'h200, 32'd0, 32'd0, 1'b0);
        bus.br_target = 32'h0000_0301;
        step();
        expect_state("br2_b", 32'h300, 32'd0, 32'd0, 1'b0);

        // Redirect together with freeze: redirect wins.
        bus.freeze    = 1'b1;
        bus.br_target = 32'h0000_1000;
        step();
        expect_state("br_freeze", 32'h1000, 32'd0, 32'd0, 1'b0);
        bus.br_taken = 1'b0;
        step();
        expect_state("freeze_bubble", 32'h1000, 32'd0, 32'd0, 1'b0);
        bus.freeze = 1'b0;
        step();
        expect_state("after_bubble", 32'h1004, 32'h1004, 32'h1000, 1'b1);

        // PC wrap at top of address space.
        bus.br_taken  = 1'b1;
        bus.br_target = 32'hFFFF_FFFF;
        step();
        expect_state("to_top", 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0);
        bus.br_taken = 1'b0;
        step();
        expect_state("wrap", 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b1);
        step();
        expect_state("wrap_next", 32'd4, 32'd4, 32'd0, 1'b1);

        // Reset while frozen.
        bus.freeze = 1'b1;
        rst        = 1'b1;
        step();
        expect_state("rst_freeze", 32'd0, 32'd0, 32'd0, 1'b0);
        rst        = 1'b0;
        bus.freeze = 1'b0;
        step();
        step();
        expect_state("post_rst", 32'd8, 32'd8, 32'd4, 1'b1);

        // Reset while redirecting.
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_0080;
        rst           = 1'b1;
        step();
        expect_state("rst_branch", 32'd0, 32'd0, 32'd0, 1'b0);
        rst          = 1'b0;
        bus.br_taken = 1'b0;
        step();
        expect_state("post_rst2", 32'd4, 32'd4, 32'd0, 1'b1);

`ifdef IF_FETCH_PERF_CNT_EN
        // Counters: 6 advance, 3 freeze, 1 redirect after a reset.
        rst = 1'b1;
        step();
        check("cnt_rst.fetch", bus.fetch_count, 32'd0);
        check("cnt_rst.stall", bus.stall_count, 32'd0);
        check("cnt_rst.flush", bus.flush_count, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.freeze   = (i >= 6 && i < 9);
            bus.br_taken = (i == 9);
            step();
        end
        bus.freeze   = 1'b0;
        bus.br_taken = 1'b0;
        check("cnt.fetch", bus.fetch_count, 32'd6);
        check("cnt.stall", bus.stall_count, 32'd3);
        check("cnt.flush", bus.flush_count, 32'd1);
        $display("counters: fetch=%0d stall=%0d flush=%0d",
                 bus.fetch_count, bus.stall_count, bus.flush_count);
        rst = 1'b1;
        step();
        check("cnt_clr.fetch", bus.fetch_count, 32'd0);
        check("cnt_clr.stall", bus.stall_count, 32'd0);
        check("cnt_clr.flush", bus.flush_count, 32'd0);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
